// File: rtl/xor_decrypt.sv
// xor_decrypt: iterative block decryptor that XORs CHUNK_W bits per clock with a replicated key.
// Takes a DATA_W ciphertext block through a valid/ready handshake and returns plaintext with the same handshake.
module xor_decrypt #(
  parameter int DATA_W  = 256,
  parameter int KEY_W   = 8,
  parameter int CHUNK_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [KEY_W-1:0]  key,
  input  logic [DATA_W-1:0] code,
  output logic [DATA_W-1:0] code_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [31:0]       blk_count
);

  localparam int NBEATS = DATA_W / CHUNK_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state;
  logic [KEY_W-1:0]    key_q;
  logic [DATA_W-1:0]   work;
  logic [DATA_W-1:0]   work_next;
  logic [BEAT_W-1:0]   beat;
  logic [CHUNK_W-1:0]  key_lane;

  assign key_lane = {(CHUNK_W / KEY_W){key_q}};

  // Constant-index chunk select keeps the per-beat XOR a plain lane mux.
  always_comb begin
    work_next = work;
    for (int i = 0; i < NBEATS; i++) begin
      if (beat == BEAT_W'(i)) begin
        work_next[i*CHUNK_W +: CHUNK_W] = work[i*CHUNK_W +: CHUNK_W] ^ key_lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready_in  <= 1'b1;
      valid_out <= 1'b0;
      code_out  <= '0;
      blk_count <= '0;
      beat      <= '0;
      key_q     <= '0;
      work      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && ready_in) begin
            key_q    <= key;
            work     <= code;
            beat     <= '0;
            ready_in <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          work <= work_next;
          beat <= beat + 1'b1;
          // code_out only updates here, so it holds the previous plaintext until the next block completes.
          if (beat == LAST_BEAT) begin
            code_out  <= work_next;
            valid_out <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (valid_out && ready_out) begin
            valid_out <= 1'b0;
            ready_in  <= 1'b1;
            blk_count <= blk_count + 32'd1;
            state     <= IDLE;
          end
        end
        default: begin
          valid_out <= 1'b0;
          ready_in  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_decrypt.sv
// tb_xor_decrypt: directed bench for xor_decrypt with a plaintext scoreboard.
// Expected plaintext is queued on each input handshake and compared on each output handshake.
module tb_xor_decrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic         ready_in;
  logic [7:0]   key;
  logic [255:0] code;
  logic [255:0] code_out;
  logic         valid_out;
  logic         ready_out;
  logic [31:0]  blk_count;

  logic [255:0] sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [31:0]  exp_count = '0;
  int           cycle = 0;

  always #5 clk = ~clk;

  xor_decrypt dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .key       (key),
    .code      (code),
    .code_out  (code_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .blk_count (blk_count)
  );

  function automatic logic [255:0] rep(input logic [7:0] k);
    return {32{k}};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes seen before the edge, then check blk_count after it.
  task automatic step();
    logic in_hs;
    logic out_hs;
    logic [255:0] exp_pt;
    in_hs  = valid_in && ready_in && !rst;
    out_hs = valid_out && ready_out && !rst;
    if (out_hs) begin
      checkOutput("output_expected", 256'(sb.size() > 0), 256'(1));
      if (sb.size() > 0) begin
        exp_pt = sb.pop_front();
        checkOutput("plaintext", code_out, exp_pt);
      end
      exp_count = exp_count + 32'd1;
    end
    if (in_hs) sb.push_back(code ^ rep(key));
    if (rst) begin
      sb.delete();
      exp_count = '0;
    end
    @(posedge clk);
    #1;
    cycle++;
    checkOutput("blk_count", 256'(blk_count), 256'(exp_count));
  endtask

  // Drive one block and return the cycle index of its accepting edge.
  task automatic applyStimulus(input logic [7:0] k, input logic [255:0] c, output int acc_cycle);
    int n;
    n = 0;
    valid_in = 1'b1;
    key      = k;
    code     = c;
    while (!ready_in && n < 50) begin
      step();
      n++;
    end
    checkOutput("accept_timeout", 256'(ready_in), 256'(1));
    step();
    acc_cycle = cycle;
    valid_in  = 1'b0;
    key       = 8'($urandom);
    code      = rand256();
  endtask

  task automatic wait_valid(input int max_cycles, output int vcycle);
    int n;
    n = 0;
    while (!valid_out && n < max_cycles) begin
      step();
      n++;
    end
    checkOutput("valid_timeout", 256'(valid_out), 256'(1));
    vcycle = cycle;
  endtask

  initial begin
    int a;
    int v;
    int accepts[$];
    logic hs;
    logic [7:0] k;
    logic [255:0] pt;
    logic [255:0] held;

    rst       = 1'b1;
    valid_in  = 1'b0;
    key       = '0;
    code      = '0;
    ready_out = 1'b0;
    step();
    step();
    rst = 1'b0;
    checkOutput("reset_ready_in", 256'(ready_in), 256'(1));
    checkOutput("reset_valid_out", 256'(valid_out), 256'(0));
    checkOutput("reset_code_out", code_out, 256'(0));
    checkOutput("reset_blk_count", 256'(blk_count), 256'(0));

    // Matching key and ciphertext decrypt to zero, eight cycles after accept.
    ready_out = 1'b1;
    applyStimulus(8'hA5, {32{8'hA5}}, a);
    wait_valid(20, v);
    checkOutput("t1_latency", 256'(v - a), 256'(8));
    checkOutput("t1_zero", code_out, 256'(0));
    step();
    checkOutput("t1_count", 256'(blk_count), 256'(1));
    checkOutput("t1_ready_in_idle", 256'(ready_in), 256'(1));
    checkOutput("t1_valid_drop", 256'(valid_out), 256'(0));

    // Round trip: ciphertext is built by encrypting the plaintext with the same key.
    for (int i = 0; i < 100; i++) begin
      if (i == 0) begin
        k  = 8'h3C;
        pt = {4{64'h0123456789ABCDEF}};
      end else begin
        k  = 8'($urandom);
        pt = rand256();
      end
      applyStimulus(k, pt ^ rep(k), a);
      wait_valid(20, v);
      if (i == 0) checkOutput("t2_first_pt", code_out, {4{64'h0123456789ABCDEF}});
      step();
    end

    // Backpressure in DONE.
    ready_out = 1'b0;
    applyStimulus(8'hC3, rand256(), a);
    wait_valid(20, v);
    held = code_out;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("t3_valid_held", 256'(valid_out), 256'(1));
      checkOutput("t3_code_stable", code_out, held);
      checkOutput("t3_ready_in_low", 256'(ready_in), 256'(0));
    end
    ready_out = 1'b1;
    step();
    checkOutput("t3_single_inc", 256'(blk_count), 256'(102));
    checkOutput("t3_valid_drop", 256'(valid_out), 256'(0));

    // New block offered mid-RUN is ignored until the DUT returns to IDLE.
    applyStimulus(8'h5A, rand256(), a);
    step();
    step();
    valid_in = 1'b1;
    key      = 8'hFF;
    code     = rand256();
    wait_valid(20, v);
    checkOutput("t4_latency", 256'(v - a), 256'(8));
    checkOutput("t4_ready_in_done", 256'(ready_in), 256'(0));
    checkOutput("t4_pending_blocks", 256'(sb.size()), 256'(1));
    step();
    checkOutput("t4_ready_in_idle", 256'(ready_in), 256'(1));
    step();
    a = cycle;
    valid_in = 1'b0;
    wait_valid(20, v);
    checkOutput("t4_second_latency", 256'(v - a), 256'(8));
    step();

    // Reset at beat 3 discards the block in flight.
    applyStimulus(8'h77, rand256(), a);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t5_valid_out", 256'(valid_out), 256'(0));
    checkOutput("t5_ready_in", 256'(ready_in), 256'(1));
    checkOutput("t5_blk_count", 256'(blk_count), 256'(0));
    checkOutput("t5_code_out", code_out, 256'(0));
    rst      = 1'b1;
    valid_in = 1'b1;
    code     = rand256();
    step();
    rst      = 1'b0;
    valid_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      checkOutput("t5_no_output", 256'(valid_out), 256'(0));
    end

    // Back-to-back blocks with valid_in and ready_out held high.
    valid_in  = 1'b1;
    ready_out = 1'b1;
    key       = 8'($urandom);
    code      = rand256();
    for (int n = 0; n < 60 && accepts.size() < 4; n++) begin
      hs = valid_in && ready_in;
      step();
      if (hs) begin
        accepts.push_back(cycle);
        key  = 8'($urandom);
        code = rand256();
        if (accepts.size() == 4) valid_in = 1'b0;
      end
    end
    valid_in = 1'b0;
    checkOutput("t6_accepts", 256'(accepts.size()), 256'(4));
    for (int i = 1; i < accepts.size(); i++) begin
      checkOutput("t6_period", 256'(accepts[i] - accepts[i-1]), 256'(10));
    end
    wait_valid(20, v);
    step();
    checkOutput("t6_blk_count", 256'(blk_count), 256'(4));
    checkOutput("sb_drained", 256'(sb.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
